// File: rtl/alu_exec_unit.sv
// EX-stage unit: ALU control decode, single-cycle ALU, iterative multiplier,
// valid/ready handshake toward ID/EX, flush and illegal-op flag.
//
// state   | meaning
// ST_IDLE | ready for a new op; single-cycle ops complete here
// ST_MUL  | iterative multiply in progress, ready_o low
module alu_exec_unit #(
  parameter int XLEN     = 32,
  parameter int MUL_BITS = 1
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            valid_i,
  output logic            ready_o,
  input  logic [9:0]      funct_i,
  input  logic [1:0]      ALUOp_i,
  input  logic [XLEN-1:0] src1_i,
  input  logic [XLEN-1:0] src2_i,
  input  logic            flush_i,
  output logic            valid_o,
  output logic [XLEN-1:0] result_o,
  output logic            err_o
);

  localparam int SHW = $clog2(XLEN);
  localparam int CW  = $clog2(XLEN + 1);
  localparam logic [CW-1:0] NSTEP = CW'(XLEN / MUL_BITS);

  typedef enum logic {ST_IDLE, ST_MUL} state_e;
  typedef enum logic [3:0] {
    OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SLL, OP_SRL, OP_SRA, OP_MUL, OP_ILL
  } op_e;

  state_e          r_state, w_state_nxt;
  op_e             w_op;
  logic            w_accept, w_done;
  logic [SHW-1:0]  w_shamt;
  logic [XLEN-1:0] w_alu, w_digit, w_acc_nxt;
  logic [XLEN-1:0] r_mcand, r_mplier, r_acc, r_result;
  logic [CW-1:0]   r_cnt;
  logic            r_valid, r_err;

  assign w_shamt = src2_i[SHW-1:0];

  always_comb begin
    w_op = OP_ILL;
    case (ALUOp_i)
      2'b00: w_op = OP_ADD;
      2'b01: w_op = OP_SUB;
      2'b11: begin
        if (funct_i[2:0] == 3'b000)           w_op = OP_ADD;
        else if (funct_i == 10'b0100000_101) w_op = OP_SRA;
      end
      default: begin
        case (funct_i)
          10'b0000000_111: w_op = OP_AND;
          10'b0000000_110: w_op = OP_OR;
          10'b0000000_100: w_op = OP_XOR;
          10'b0000000_001: w_op = OP_SLL;
          10'b0000000_101: w_op = OP_SRL;
          10'b0100000_101: w_op = OP_SRA;
          10'b0000000_000: w_op = OP_ADD;
          10'b0100000_000: w_op = OP_SUB;
          10'b0000001_000: w_op = OP_MUL;
          default:         w_op = OP_ILL;
        endcase
      end
    endcase
  end

  // MUL and illegal ops leave the ALU output at zero
  always_comb begin
    w_alu = '0;
    case (w_op)
      OP_ADD:  w_alu = src1_i + src2_i;
      OP_SUB:  w_alu = src1_i - src2_i;
      OP_AND:  w_alu = src1_i & src2_i;
      OP_OR:   w_alu = src1_i | src2_i;
      OP_XOR:  w_alu = src1_i ^ src2_i;
      OP_SLL:  w_alu = src1_i << w_shamt;
      OP_SRL:  w_alu = src1_i >> w_shamt;
      OP_SRA:  w_alu = $unsigned($signed(src1_i) >>> w_shamt);
      default: w_alu = '0;
    endcase
  end

  assign w_digit   = XLEN'(r_mplier[MUL_BITS-1:0]);
  assign w_acc_nxt = r_acc + r_mcand * w_digit;

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_done      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_accept = valid_i && !flush_i;
        if (w_accept && (w_op == OP_MUL)) w_state_nxt = ST_MUL;
      end
      ST_MUL: begin
        if (flush_i) begin
          w_state_nxt = ST_IDLE;
        end else if (r_cnt == CW'(1)) begin
          w_done      = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_mcand  <= '0;
      r_mplier <= '0;
      r_acc    <= '0;
      r_cnt    <= '0;
      r_result <= '0;
      r_valid  <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      if (flush_i) begin
        r_cnt <= '0;
      end else if (w_accept) begin
        if (w_op == OP_MUL) begin
          r_mcand  <= src1_i;
          r_mplier <= src2_i;
          r_acc    <= '0;
          r_cnt    <= NSTEP;
        end else begin
          r_result <= w_alu;
          r_err    <= (w_op == OP_ILL);
          r_valid  <= 1'b1;
        end
      end else if (r_state == ST_MUL) begin
        r_acc    <= w_acc_nxt;
        r_mcand  <= r_mcand << MUL_BITS;
        r_mplier <= r_mplier >> MUL_BITS;
        r_cnt    <= r_cnt - CW'(1);
        if (w_done) begin
          r_result <= w_acc_nxt;
          r_err    <= 1'b0;
          r_valid  <= 1'b1;
        end
      end
    end
  end

  assign ready_o  = (r_state == ST_IDLE);
  assign valid_o  = r_valid;
  assign result_o = r_result;
  assign err_o    = r_err;

endmodule
